// File: rtl/branch_predict_ctrl.sv
// Branch predictor and resolution controller: per-PC 2-bit BHT lookup in IF,
// branch resolution/training in EX, mispredict redirect with a timed IF/ID flush.
module branch_predict_ctrl #(
    parameter int IDX_BITS  = 4,
    parameter int FLUSH_CYC = 2,
    parameter int CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [31:0]      if_pc,
    output logic             pred_taken,
    input  logic             ex_valid,
    input  logic             ex_branch,
    input  logic [2:0]       ex_func3,
    input  logic             ex_zero,
    input  logic             ex_pos,
    input  logic [31:0]      ex_pc,
    input  logic             ex_pred_taken,
    input  logic             stall,
    output logic             actual_taken,
    output logic             mispredict,
    output logic [1:0]       pc_src,
    output logic             flush,
    output logic [CNT_W-1:0] branch_cnt,
    output logic [CNT_W-1:0] mispred_cnt
);

    localparam int DEPTH = 2 ** IDX_BITS;

    localparam logic [2:0] F3_BEQ = 3'b000;
    localparam logic [2:0] F3_BNE = 3'b001;
    localparam logic [2:0] F3_BLT = 3'b100;
    localparam logic [2:0] F3_BGE = 3'b101;

    localparam logic [1:0] PC_SEQ    = 2'b00;
    localparam logic [1:0] PC_TARGET = 2'b01;
    localparam logic [1:0] PC_NEXT   = 2'b10;

    localparam logic [2:0] FLUSH_LOAD = 3'(FLUSH_CYC - 1);

    typedef enum logic {
        IDLE,
        FLUSH
    } state_t;

    state_t               state;
    logic [2:0]           flush_left;
    logic [1:0]           bht [DEPTH];
    logic [IDX_BITS-1:0]  if_idx;
    logic [IDX_BITS-1:0]  ex_idx;
    logic                 res;
    logic                 legal;
    logic                 cond;
    logic                 train;

    // Two-bit saturating counter step: no wrap at either end.
    function automatic logic [1:0] bht_next(input logic [1:0] c, input logic taken);
        logic [1:0] n;
        n = c;
        if (taken) begin
            if (c != 2'b11) n = c + 2'b01;
        end else begin
            if (c != 2'b00) n = c - 2'b01;
        end
        return n;
    endfunction

    assign if_idx     = if_pc[IDX_BITS+1:2];
    assign ex_idx     = ex_pc[IDX_BITS+1:2];
    assign pred_taken = bht[if_idx][1];

    always_comb begin
        legal = 1'b1;
        cond  = 1'b0;
        case (ex_func3)
            F3_BEQ:  cond = ex_zero;
            F3_BNE:  cond = ~ex_zero;
            F3_BLT:  cond = ~ex_zero & ~ex_pos;
            F3_BGE:  cond = ex_zero | ex_pos;
            default: legal = 1'b0;
        endcase
    end

    // Squashed slots during FLUSH and stalled EX never resolve.
    assign res          = ex_valid & ex_branch & ~stall & (state == IDLE);
    assign train        = res & legal;
    assign actual_taken = legal & cond;
    assign mispredict   = train & (actual_taken != ex_pred_taken);

    always_comb begin
        pc_src = PC_SEQ;
        if (mispredict) pc_src = actual_taken ? PC_TARGET : PC_NEXT;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) bht[i] <= 2'b01;
            branch_cnt  <= '0;
            mispred_cnt <= '0;
        end else if (train) begin
            bht[ex_idx] <= bht_next(bht[ex_idx], actual_taken);
            branch_cnt  <= branch_cnt + 1'b1;
            if (mispredict) mispred_cnt <= mispred_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            flush      <= 1'b0;
            flush_left <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (mispredict) begin
                        state      <= FLUSH;
                        flush      <= 1'b1;
                        flush_left <= FLUSH_LOAD;
                    end
                end
                FLUSH: begin
                    if (flush_left == 3'd0) begin
                        state <= IDLE;
                        flush <= 1'b0;
                    end else begin
                        flush_left <= flush_left - 3'd1;
                    end
                end
                default: begin
                    state <= IDLE;
                    flush <= 1'b0;
                end
            endcase
        end
    end

    logic unused_pc_bits;
    assign unused_pc_bits = ^{if_pc[31:IDX_BITS+2], if_pc[1:0],
                              ex_pc[31:IDX_BITS+2], ex_pc[1:0]};

endmodule

// File: tb/tb_branch_predict_ctrl.sv
// Directed bench for branch_predict_ctrl: lookup, training, saturation,
// mispredict redirect/flush, stall gating, same-cycle lookup/update, reset in flush.
module tb_branch_predict_ctrl;

    logic        clk;
    logic        rst_n;
    logic [31:0] if_pc;
    logic        pred_taken;
    logic        ex_valid;
    logic        ex_branch;
    logic [2:0]  ex_func3;
    logic        ex_zero;
    logic        ex_pos;
    logic [31:0] ex_pc;
    logic        ex_pred_taken;
    logic        stall;
    logic        actual_taken;
    logic        mispredict;
    logic [1:0]  pc_src;
    logic        flush;
    logic [15:0] branch_cnt;
    logic [15:0] mispred_cnt;

    int n_cmp;
    int n_err;

    branch_predict_ctrl #(.IDX_BITS(4), .FLUSH_CYC(2), .CNT_W(16)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .if_pc         (if_pc),
        .pred_taken    (pred_taken),
        .ex_valid      (ex_valid),
        .ex_branch     (ex_branch),
        .ex_func3      (ex_func3),
        .ex_zero       (ex_zero),
        .ex_pos        (ex_pos),
        .ex_pc         (ex_pc),
        .ex_pred_taken (ex_pred_taken),
        .stall         (stall),
        .actual_taken  (actual_taken),
        .mispredict    (mispredict),
        .pc_src        (pc_src),
        .flush         (flush),
        .branch_cnt    (branch_cnt),
        .mispred_cnt   (mispred_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ex(input logic v, input logic [2:0] f3, input logic z, input logic p,
                          input logic [31:0] pc, input logic pr);
        ex_valid      = v;
        ex_branch     = 1'b1;
        ex_func3      = f3;
        ex_zero       = z;
        ex_pos        = p;
        ex_pc         = pc;
        ex_pred_taken = pr;
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst_n = 1'b0;
        if_pc = 32'h0;
        stall = 1'b0;
        set_ex(1'b0, 3'b000, 1'b0, 1'b0, 32'h0, 1'b0);
        ex_branch = 1'b0;
        repeat (3) tick();
        rst_n = 1'b1;
        #1;

        // 1: reset state, every entry weak not-taken
        for (int i = 0; i < 16; i++) begin
            if_pc = 32'(i * 4);
            #1;
            chk($sformatf("rst_pred[%0d]", i), 32'(pred_taken), 32'd0);
        end
        chk("rst_branch_cnt", 32'(branch_cnt), 32'd0);
        chk("rst_mispred_cnt", 32'(mispred_cnt), 32'd0);
        chk("rst_flush", 32'(flush), 32'd0);
        chk("rst_pc_src", 32'(pc_src), 32'd0);

        // 2: BEQ taken at 0x40 three times, first one mispredicts
        tick();
        if_pc = 32'h40;
        set_ex(1'b1, 3'b000, 1'b1, 1'b0, 32'h40, 1'b0);
        #1;
        chk("beq1_pred", 32'(pred_taken), 32'd0);
        chk("beq1_actual", 32'(actual_taken), 32'd1);
        chk("beq1_mispredict", 32'(mispredict), 32'd1);
        chk("beq1_pc_src", 32'(pc_src), 32'd1);
        tick();
        ex_valid = 1'b0;
        #1;
        chk("beq1_flush_c1", 32'(flush), 32'd1);
        chk("beq1_bht_10", 32'(pred_taken), 32'd1);
        tick();
        chk("beq1_flush_c2", 32'(flush), 32'd1);
        tick();
        chk("beq1_flush_off", 32'(flush), 32'd0);
        set_ex(1'b1, 3'b000, 1'b1, 1'b0, 32'h40, 1'b1);
        #1;
        chk("beq2_mispredict", 32'(mispredict), 32'd0);
        chk("beq2_pc_src", 32'(pc_src), 32'd0);
        tick();
        chk("beq2_flush", 32'(flush), 32'd0);
        tick();
        ex_valid = 1'b0;
        #1;
        chk("beq3_sat_pred", 32'(pred_taken), 32'd1);
        chk("beq_branch_cnt", 32'(branch_cnt), 32'd3);
        chk("beq_mispred_cnt", 32'(mispred_cnt), 32'd1);

        // 3: BLT not taken but predicted taken; following EX slots squashed
        if_pc = 32'h48;
        set_ex(1'b1, 3'b100, 1'b0, 1'b1, 32'h44, 1'b1);
        #1;
        chk("blt_actual", 32'(actual_taken), 32'd0);
        chk("blt_mispredict", 32'(mispredict), 32'd1);
        chk("blt_pc_src", 32'(pc_src), 32'd2);
        tick();
        set_ex(1'b1, 3'b000, 1'b1, 1'b0, 32'h48, 1'b0);
        #1;
        chk("sq1_flush", 32'(flush), 32'd1);
        chk("sq1_mispredict", 32'(mispredict), 32'd0);
        chk("sq1_pc_src", 32'(pc_src), 32'd0);
        tick();
        chk("sq2_flush", 32'(flush), 32'd1);
        chk("sq2_mispredict", 32'(mispredict), 32'd0);
        tick();
        ex_valid = 1'b0;
        #1;
        chk("sq_flush_off", 32'(flush), 32'd0);
        chk("sq_branch_cnt", 32'(branch_cnt), 32'd4);
        chk("sq_mispred_cnt", 32'(mispred_cnt), 32'd2);
        chk("sq_bht2_untouched", 32'(pred_taken), 32'd0);

        // 4: stall holds a mispredicting BNE
        stall = 1'b1;
        set_ex(1'b1, 3'b001, 1'b1, 1'b0, 32'h4C, 1'b1);
        #1;
        chk("stall_mispredict", 32'(mispredict), 32'd0);
        chk("stall_pc_src", 32'(pc_src), 32'd0);
        tick();
        chk("stall_branch_cnt", 32'(branch_cnt), 32'd4);
        chk("stall_flush", 32'(flush), 32'd0);
        stall = 1'b0;
        #1;
        chk("unstall_mispredict", 32'(mispredict), 32'd1);
        chk("unstall_pc_src", 32'(pc_src), 32'd2);
        tick();
        ex_valid = 1'b0;
        #1;
        chk("bne_branch_cnt", 32'(branch_cnt), 32'd5);
        chk("bne_mispred_cnt", 32'(mispred_cnt), 32'd3);
        chk("bne_flush", 32'(flush), 32'd1);
        tick();
        tick();
        chk("bne_flush_off", 32'(flush), 32'd0);

        // 5: same-index lookup and update, no bypass
        if_pc = 32'h48;
        set_ex(1'b1, 3'b000, 1'b1, 1'b0, 32'h48, 1'b1);
        #1;
        chk("same_old_pred", 32'(pred_taken), 32'd0);
        chk("same_mispredict", 32'(mispredict), 32'd0);
        tick();
        ex_valid = 1'b0;
        #1;
        chk("same_new_pred", 32'(pred_taken), 32'd1);
        chk("same_branch_cnt", 32'(branch_cnt), 32'd6);

        // 6: async reset while flushing, then an illegal func3
        set_ex(1'b1, 3'b000, 1'b0, 1'b0, 32'h48, 1'b1);
        #1;
        chk("pre_rst_mispredict", 32'(mispredict), 32'd1);
        tick();
        ex_valid = 1'b0;
        #1;
        chk("pre_rst_flush", 32'(flush), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("rst_mid_flush", 32'(flush), 32'd0);
        chk("rst_mid_branch_cnt", 32'(branch_cnt), 32'd0);
        #1;
        rst_n = 1'b1;
        if_pc = 32'h40;
        set_ex(1'b1, 3'b010, 1'b1, 1'b1, 32'h40, 1'b1);
        #1;
        chk("f3_010_actual", 32'(actual_taken), 32'd0);
        chk("f3_010_mispredict", 32'(mispredict), 32'd0);
        chk("f3_010_pc_src", 32'(pc_src), 32'd0);
        tick();
        ex_valid = 1'b0;
        #1;
        chk("f3_010_branch_cnt", 32'(branch_cnt), 32'd0);
        chk("f3_010_mispred_cnt", 32'(mispred_cnt), 32'd0);
        chk("f3_010_flush", 32'(flush), 32'd0);
        chk("f3_010_bht", 32'(pred_taken), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
